convolver_control: RTL and testbench

- Sequencing controller for the 3x3 convolver datapath; the stage the datapath's three_shift and weight_write inputs come from.
- Loads nine kernel weights through a valid/ready handshake.
- Streams image columns (three vertically adjacent pixels, supplied by the upstream line buffer) into the datapath window.
- Flags when the datapath result is a valid full-window convolution.

---
 rtl/convolver_control.sv | 174 +++++++++++++++++
 tb/tb_convolver_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/convolver_control.sv
// Sequencing controller for the 3x3 convolver datapath: loads nine kernel
// weights, streams 3-pixel columns into the window and flags full-window results.
module convolver_control #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             weight_valid,
  output logic             weight_ready,
  output logic             weight_write,
  output logic [3:0]       weight_addr,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic             three_shift,
  output logic             window_valid,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic             w_acc;
  logic             p_acc;
  logic             last_col;
  logic             last_row;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ncol_q, ncol_d;
  logic [CNT_W-1:0] nrow_q, nrow_d;
  logic             weight_write_q, weight_write_d;
  logic [3:0]       weight_addr_q, weight_addr_d;
  logic             three_shift_q, three_shift_d;
  logic             window_valid_q, window_valid_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             done_q, done_d;

  assign w_acc    = weight_valid & weight_ready;
  assign p_acc    = pixel_valid & pixel_ready;
  assign last_col = (ncol_q == CNT_W'(IMG_W - 1));
  assign last_row = (nrow_q == CNT_W'(IMG_H - 3));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD_W;
        else       state_d = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (w_acc && (wcnt_q == 4'd8)) state_d = ST_STREAM;
        else                           state_d = ST_LOAD_W;
      end
      ST_STREAM: begin
        if (p_acc && last_col && last_row) state_d = ST_DRAIN;
        else                               state_d = ST_STREAM;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and status decode; depends on state only, never on inputs
  always_comb begin
    weight_ready = 1'b0;
    pixel_ready  = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE:   busy         = 1'b0;
      ST_LOAD_W: weight_ready = 1'b1;
      ST_STREAM: pixel_ready  = 1'b1;
      ST_DRAIN:  busy         = 1'b1;
      ST_DONE:   busy         = 1'b1;
      default:   busy         = 1'b0;
    endcase
  end

  // Counters and strobe next values; window_valid trails three_shift by one cycle
  always_comb begin
    wcnt_d         = wcnt_q;
    ncol_d         = ncol_q;
    nrow_d         = nrow_q;
    weight_addr_d  = weight_addr_q;
    row_d          = row_q;
    col_d          = col_q;
    weight_write_d = 1'b0;
    three_shift_d  = 1'b0;
    window_valid_d = three_shift_q && (col_q >= CNT_W'(2));
    done_d         = (state_q == ST_DRAIN);
    if ((state_q == ST_IDLE) && start) begin
      wcnt_d        = 4'd0;
      ncol_d        = {CNT_W{1'b0}};
      nrow_d        = {CNT_W{1'b0}};
      weight_addr_d = 4'd0;
      row_d         = {CNT_W{1'b0}};
      col_d         = {CNT_W{1'b0}};
    end else if (w_acc) begin
      weight_write_d = 1'b1;
      weight_addr_d  = wcnt_q;
      wcnt_d         = wcnt_q + 4'd1;
    end else if (p_acc) begin
      three_shift_d = 1'b1;
      row_d         = nrow_q;
      col_d         = ncol_q;
      if (last_col) begin
        ncol_d = {CNT_W{1'b0}};
        nrow_d = nrow_q + CNT_W'(1);
      end else begin
        ncol_d = ncol_q + CNT_W'(1);
      end
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Datapath-control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q         <= 4'd0;
      ncol_q         <= {CNT_W{1'b0}};
      nrow_q         <= {CNT_W{1'b0}};
      weight_write_q <= 1'b0;
      weight_addr_q  <= 4'd0;
      three_shift_q  <= 1'b0;
      window_valid_q <= 1'b0;
      row_q          <= {CNT_W{1'b0}};
      col_q          <= {CNT_W{1'b0}};
      done_q         <= 1'b0;
    end else begin
      wcnt_q         <= wcnt_d;
      ncol_q         <= ncol_d;
      nrow_q         <= nrow_d;
      weight_write_q <= weight_write_d;
      weight_addr_q  <= weight_addr_d;
      three_shift_q  <= three_shift_d;
      window_valid_q <= window_valid_d;
      row_q          <= row_d;
      col_q          <= col_d;
      done_q         <= done_d;
    end
  end

  assign weight_write = weight_write_q;
  assign weight_addr  = weight_addr_q;
  assign three_shift  = three_shift_q;
  assign window_valid = window_valid_q;
  assign row          = row_q;
  assign col          = col_q;
  assign done         = done_q;

endmodule

// File: tb/tb_convolver_control.sv
// Directed self-checking bench for convolver_control (default 8x8 image).
module tb_convolver_control;

  localparam int W = 8;
  localparam int H = 8;
  localparam int NCOL = W * (H - 2);

  logic       clk;
  logic       reset;
  logic       start;
  logic       weight_valid;
  logic       weight_ready;
  logic       weight_write;
  logic [3:0] weight_addr;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       three_shift;
  logic       window_valid;
  logic [7:0] row;
  logic [7:0] col;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  convolver_control #(.IMG_W(W), .IMG_H(H), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .weight_write(weight_write), .weight_addr(weight_addr),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .three_shift(three_shift), .window_valid(window_valid),
    .row(row), .col(col), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, weight_ready, weight_write, weight_addr, pixel_ready,
            three_shift, window_valid, row, col, busy, done};
  endfunction

  task automatic do_start();
    weight_valid = 1'b0;
    pixel_valid  = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_wready", weight_ready, 1'b1);
    chk("start_pready", pixel_ready, 1'b0);
    chk("start_waddr_clr", weight_addr, 4'd0);
    chk("start_row_clr", row, 8'd0);
    chk("start_col_clr", col, 8'd0);
  endtask

  // weight_valid gaps precede indices 3 and 6; pixel_valid held high throughout
  task automatic load_weights();
    logic [10:0] pat;
    int k;
    pat = 11'b11101110111;
    k = 0;
    for (int c = 0; c < 11; c++) begin
      weight_valid = pat[c];
      pixel_valid  = 1'b1;
      @(negedge clk);
      chk("wwrite", weight_write, pat[c]);
      if (pat[c]) begin
        chk("waddr", weight_addr, k);
        k++;
      end
      chk("ts_in_load", three_shift, 1'b0);
    end
    weight_valid = 1'b0;
    pixel_valid  = 1'b0;
    chk("stream_pready", pixel_ready, 1'b1);
    chk("stream_wready", weight_ready, 1'b0);
  endtask

  task automatic stream_frame(input bit toggle, input bit illegal, input int abort_k);
    int  k, ts_n, wv_n, dn_n, col_prev, row_exp, col_exp;
    bit  acc, ts_prev, last_prev, done_prev, exp_done, finished;
    k = 0; ts_n = 0; wv_n = 0; dn_n = 0; col_prev = 0; row_exp = 0; col_exp = 0;
    ts_prev = 1'b0; last_prev = 1'b0; done_prev = 1'b0; finished = 1'b0;
    for (int c = 0; c < 300; c++) begin
      pixel_valid  = toggle ? (c % 2 == 0) : 1'b1;
      start        = illegal && (c == 5);
      weight_valid = illegal;
      acc = pixel_valid && (k < NCOL);
      @(negedge clk);
      if (acc) begin
        row_exp = k / W;
        col_exp = k % W;
      end
      exp_done = ts_prev && last_prev;
      chk("three_shift", three_shift, acc);
      chk("window_valid", window_valid, ts_prev && (col_prev >= 2));
      chk("done", done, exp_done);
      chk("row", row, row_exp);
      chk("col", col, col_exp);
      chk("busy", busy, !done_prev);
      chk("wwrite_stream", weight_write, 1'b0);
      ts_n += int'(three_shift);
      wv_n += int'(window_valid);
      dn_n += int'(done);
      if (acc) begin
        col_prev  = k % W;
        last_prev = (k == NCOL - 1);
        k++;
      end
      chk("pready", pixel_ready, k < NCOL);
      ts_prev = acc;
      if (acc && (abort_k >= 0) && (k - 1 == abort_k)) begin
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 32'd0);
        @(negedge clk);
        chk("rst_held_outs", all_outs(), 32'd0);
        reset = 1'b1;
        pixel_valid = 1'b0;
        return;
      end
      if (done_prev) begin
        finished = 1'b1;
        break;
      end
      done_prev = exp_done;
    end
    start = 1'b0;
    weight_valid = 1'b0;
    pixel_valid = 1'b0;
    chk("frame_finished", finished, 1'b1);
    chk("ts_count", ts_n, NCOL);
    chk("wv_count", wv_n, (W - 2) * (H - 2));
    chk("done_count", dn_n, 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    weight_valid = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 32'd0);

    // Backpressured frame with illegal start/weight_valid during STREAM
    do_start();
    load_weights();
    stream_frame(1'b1, 1'b1, -1);

    // Continuous frame
    do_start();
    load_weights();
    stream_frame(1'b0, 1'b0, -1);

    // Abort at row2/col4, then a clean frame
    do_start();
    load_weights();
    stream_frame(1'b0, 1'b0, 2 * W + 4);
    @(negedge clk);
    chk("post_abort_idle", all_outs(), 32'd0);
    do_start();
    load_weights();
    stream_frame(1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
